dbus_arbiter: RTL and testbench

DBUS_ARBITER -- requirements
Module: dbus_arbiter

---
 rtl/dbus_arbiter.sv | 162 ++++++++++++++++
 tb/tb_dbus_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dbus_arbiter.sv
// Data-bus arbiter: round-robin requester grant with frame timeout,
// snoop-writeback priority and a one-cycle bus turnaround between owners.
// Ports:
//   clk, reset_n             - clock, asynchronous active-low reset
//   req[NREQ]                - level-sensitive bus requests
//   frame, data_last         - granted master's transfer active / last beat
//   snoop, hit_modified      - snoop hit on a modified line (queues writeback)
//   wb_done                  - writeback complete
//   grant[NREQ], dgrant      - registered one-hot grant and its OR
//   dbus_enb, dbusy_n        - data bus driver enable, active-low busy flag
//   writeback, time_out      - writeback in progress, one-cycle timeout pulse
module dbus_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned TMO  = 15
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req,
  input  logic            frame,
  input  logic            data_last,
  input  logic            snoop,
  input  logic            hit_modified,
  input  logic            wb_done,
  output logic [NREQ-1:0] grant,
  output logic            dgrant,
  output logic            dbus_enb,
  output logic            dbusy_n,
  output logic            writeback,
  output logic            time_out
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned XW = IW + 1;
  localparam int unsigned CW = 8;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GRANT   = 3'd1;
  localparam logic [2:0] S_XFER    = 3'd2;
  localparam logic [2:0] S_WB      = 3'd3;
  localparam logic [2:0] S_RECOVER = 3'd4;

  logic [2:0]      r_state, w_state_nxt;
  logic [IW-1:0]   r_ptr, w_ptr_nxt;
  logic [IW-1:0]   r_idx, w_idx_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_wb_pend, w_wb_pend_nxt;
  logic [NREQ-1:0] r_grant, w_grant_nxt;
  logic            r_dgrant, r_dbus_enb, r_dbusy_n, r_writeback, r_time_out;
  logic            w_time_out_nxt, w_wb_clr;
  logic            w_found;
  logic [IW-1:0]   w_sel;
  logic [XW-1:0]   w_cand;
  logic [IW-1:0]   w_ptr_inc;

  // Round-robin search: first requester at or after ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_cand = XW'(r_ptr) + XW'(i);
      if (w_cand >= XW'(NREQ)) w_cand = w_cand - XW'(NREQ);
      if (!w_found && req[w_cand[IW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_cand[IW-1:0];
      end
    end
  end

  assign w_ptr_inc = (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + IW'(1);

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_idx_nxt      = r_idx;
    w_cnt_nxt      = '0;
    w_time_out_nxt = 1'b0;
    w_wb_clr       = 1'b0;
    w_grant_nxt    = '0;

    case (r_state)
      S_IDLE: begin
        if (r_wb_pend) begin
          w_state_nxt = S_WB;
          w_wb_clr    = 1'b1;
        end else if (w_found) begin
          w_state_nxt = S_GRANT;
          w_idx_nxt   = w_sel;
        end
      end
      S_GRANT: begin
        // frame wins over a simultaneous timeout
        if (frame) begin
          w_state_nxt = S_XFER;
        end else if (!req[r_idx]) begin
          w_state_nxt = S_RECOVER;
          w_ptr_nxt   = w_ptr_inc;
        end else if (r_cnt == CW'(TMO - 1)) begin
          w_state_nxt    = S_RECOVER;
          w_time_out_nxt = 1'b1;
          w_ptr_nxt      = w_ptr_inc;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_XFER: begin
        if (data_last) begin
          w_state_nxt = S_RECOVER;
          w_ptr_nxt   = w_ptr_inc;
        end
      end
      S_WB: begin
        if (wb_done) w_state_nxt = S_RECOVER;
      end
      S_RECOVER: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase

    if (w_state_nxt == S_GRANT || w_state_nxt == S_XFER) w_grant_nxt[w_idx_nxt] = 1'b1;

    // A new hit in the same cycle as entry to WB stays pending.
    w_wb_pend_nxt = (snoop && hit_modified) || (r_wb_pend && !w_wb_clr);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_wb_pend   <= 1'b0;
      r_grant     <= '0;
      r_dgrant    <= 1'b0;
      r_dbus_enb  <= 1'b0;
      r_dbusy_n   <= 1'b1;
      r_writeback <= 1'b0;
      r_time_out  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_idx       <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_wb_pend   <= w_wb_pend_nxt;
      r_grant     <= w_grant_nxt;
      r_dgrant    <= |w_grant_nxt;
      r_dbus_enb  <= (w_state_nxt == S_XFER);
      r_dbusy_n   <= !(w_state_nxt == S_XFER || w_state_nxt == S_WB);
      r_writeback <= (w_state_nxt == S_WB);
      r_time_out  <= w_time_out_nxt;
    end
  end

  assign grant     = r_grant;
  assign dgrant    = r_dgrant;
  assign dbus_enb  = r_dbus_enb;
  assign dbusy_n   = r_dbusy_n;
  assign writeback = r_writeback;
  assign time_out  = r_time_out;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter (NREQ=4, TMO=15): a vector table for the
// round-robin rotation plus hand sequences for timeout, req drop, snoop
// writeback, coalescing, async reset and frame/timeout collision.
module tb_dbus_arbiter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] req = '0;
  logic       frame = 1'b0, data_last = 1'b0, snoop = 1'b0, hit_modified = 1'b0, wb_done = 1'b0;
  logic [3:0] grant;
  logic       dgrant, dbus_enb, dbusy_n, writeback, time_out;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [3:0] req;
    logic       frame, dl, snp, wbd;
    logic [3:0] g;
    logic       en, bn, wb, to;
  } vec_t;

  vec_t vq[$];

  dbus_arbiter #(.NREQ(4), .TMO(15)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .frame(frame), .data_last(data_last),
    .snoop(snoop), .hit_modified(hit_modified), .wb_done(wb_done),
    .grant(grant), .dgrant(dgrant), .dbus_enb(dbus_enb), .dbusy_n(dbusy_n),
    .writeback(writeback), .time_out(time_out)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic chk(input string tag, input logic [3:0] g, input logic en, input logic bn,
                     input logic wb, input logic to);
    cmp({tag, ".grant"}, 32'(grant), 32'(g));
    cmp({tag, ".dgrant"}, 32'(dgrant), 32'(|g));
    cmp({tag, ".dbus_enb"}, 32'(dbus_enb), 32'(en));
    cmp({tag, ".dbusy_n"}, 32'(dbusy_n), 32'(bn));
    cmp({tag, ".writeback"}, 32'(writeback), 32'(wb));
    cmp({tag, ".time_out"}, 32'(time_out), 32'(to));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    req = '0; frame = 0; data_last = 0; snoop = 0; hit_modified = 0; wb_done = 0;
    step();
    chk({tag, ".reset"}, 4'b0000, 0, 1, 0, 0);
    reset_n = 1'b1;
  endtask

  task automatic add(input logic [3:0] r, input logic f, input logic dl, input logic s,
                     input logic wd, input logic [3:0] g, input logic en, input logic bn,
                     input logic wb, input logic to);
    vec_t v;
    v.req = r; v.frame = f; v.dl = dl; v.snp = s; v.wbd = wd;
    v.g = g; v.en = en; v.bn = bn; v.wb = wb; v.to = to;
    vq.push_back(v);
  endtask

  initial begin
    logic [3:0] g;

    // Rotation table: all requesters active, three-beat transfers.
    for (int k = 0; k < 5; k++) begin
      g = 4'b0001 << (k % 4);
      add(4'b1111, 0, 0, 0, 0, g, 0, 1, 0, 0);          // IDLE -> GRANT
      if (k < 4) begin
        add(4'b1111, 1, 0, 0, 0, g, 1, 0, 0, 0);        // GRANT -> XFER
        add(4'b1111, 1, 0, 0, 0, g, 1, 0, 0, 0);
        add(4'b1111, 1, 0, 0, 0, g, 1, 0, 0, 0);
        add(4'b1111, 1, 1, 0, 0, 4'b0000, 0, 1, 0, 0);  // last beat -> RECOVER
        add(4'b1111, 0, 0, 0, 0, 4'b0000, 0, 1, 0, 0);  // RECOVER -> IDLE
      end
    end

    do_reset("c1");
    for (int i = 0; i < vq.size(); i++) begin
      req = vq[i].req; frame = vq[i].frame; data_last = vq[i].dl;
      snoop = vq[i].snp; hit_modified = vq[i].snp; wb_done = vq[i].wbd;
      step();
      chk($sformatf("c1.v%0d", i), vq[i].g, vq[i].en, vq[i].bn, vq[i].wb, vq[i].to);
    end

    // Timeout: grant rises, time_out 15 cycles later, ptr advances to 2.
    do_reset("c2");
    req = 4'b0010;
    step(); chk("c2.grant", 4'b0010, 0, 1, 0, 0);
    for (int i = 0; i < 14; i++) begin
      step(); chk($sformatf("c2.wait%0d", i), 4'b0010, 0, 1, 0, 0);
    end
    step(); chk("c2.timeout", 4'b0000, 0, 1, 0, 1);
    req = 4'b0011;
    step(); chk("c2.idle", 4'b0000, 0, 1, 0, 0);
    step(); chk("c2.ptr2", 4'b0001, 0, 1, 0, 0);

    // Req drop before frame: no time_out, ptr advances past the dropper.
    do_reset("cd");
    req = 4'b0100;
    step(); chk("cd.grant", 4'b0100, 0, 1, 0, 0);
    req = 4'b0000;
    step(); chk("cd.drop", 4'b0000, 0, 1, 0, 0);
    req = 4'b1111;
    step(); chk("cd.idle", 4'b0000, 0, 1, 0, 0);
    step(); chk("cd.next", 4'b1000, 0, 1, 0, 0);

    // Snoop hit mid-transfer: transfer completes, then writeback, then req1.
    do_reset("c3");
    req = 4'b0011;
    step(); chk("c3.grant", 4'b0001, 0, 1, 0, 0);
    frame = 1;
    step(); chk("c3.xfer", 4'b0001, 1, 0, 0, 0);
    snoop = 1; hit_modified = 1;
    step(); chk("c3.noabort", 4'b0001, 1, 0, 0, 0);
    snoop = 0; hit_modified = 0; data_last = 1;
    step(); chk("c3.recover", 4'b0000, 0, 1, 0, 0);
    frame = 0; data_last = 0;
    step(); chk("c3.idle", 4'b0000, 0, 1, 0, 0);
    step(); chk("c3.wb", 4'b0000, 0, 0, 1, 0);
    step(); chk("c3.wbhold", 4'b0000, 0, 0, 1, 0);
    wb_done = 1;
    step(); chk("c3.wbrec", 4'b0000, 0, 1, 0, 0);
    wb_done = 0;
    step(); chk("c3.idle2", 4'b0000, 0, 1, 0, 0);
    step(); chk("c3.grant1", 4'b0010, 0, 1, 0, 0);

    // Three snoop hits during WB coalesce into a single further WB.
    do_reset("c4");
    snoop = 1; hit_modified = 1;
    step(); chk("c4.idle", 4'b0000, 0, 1, 0, 0);
    snoop = 0; hit_modified = 0;
    step(); chk("c4.wb1", 4'b0000, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      snoop = 1; hit_modified = 1;
      step(); chk($sformatf("c4.hit%0d", i), 4'b0000, 0, 0, 1, 0);
      snoop = 0; hit_modified = 0;
      step(); chk($sformatf("c4.gap%0d", i), 4'b0000, 0, 0, 1, 0);
    end
    wb_done = 1;
    step(); chk("c4.rec1", 4'b0000, 0, 1, 0, 0);
    wb_done = 0;
    step(); chk("c4.idle1", 4'b0000, 0, 1, 0, 0);
    step(); chk("c4.wb2", 4'b0000, 0, 0, 1, 0);
    wb_done = 1;
    step(); chk("c4.rec2", 4'b0000, 0, 1, 0, 0);
    wb_done = 0;
    for (int i = 0; i < 3; i++) begin
      step(); chk($sformatf("c4.nowb%0d", i), 4'b0000, 0, 1, 0, 0);
    end

    // Asynchronous reset mid-transfer; first grant afterwards uses ptr=0.
    do_reset("c5");
    req = 4'b0001;
    step(); chk("c5.grant", 4'b0001, 0, 1, 0, 0);
    frame = 1;
    step(); chk("c5.xfer", 4'b0001, 1, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1 chk("c5.async", 4'b0000, 0, 1, 0, 0);
    @(posedge clk); #1;
    frame = 0; req = 4'b1000; reset_n = 1'b1;
    step(); chk("c5.after", 4'b1000, 0, 1, 0, 0);

    // frame arrives in the very cycle the counter reaches TMO-1.
    do_reset("c6");
    req = 4'b0001;
    step(); chk("c6.grant", 4'b0001, 0, 1, 0, 0);
    for (int i = 0; i < 14; i++) begin
      step(); chk($sformatf("c6.wait%0d", i), 4'b0001, 0, 1, 0, 0);
    end
    frame = 1;
    step(); chk("c6.xfer", 4'b0001, 1, 0, 0, 0);
    step(); chk("c6.hold", 4'b0001, 1, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
